pellet_tracker: RTL and testbench
=================================

Name: pellet_tracker

Overview:
- Consumes PacMan's centre position (BallX/BallY from the motion block) once per frame.
- Maps the position to a maze tile and clears any pellet on that tile. Keeps the score and the count of remaining pellets, and flags when the level is cleared.
- Has a second, independent read port so the colour mapper can draw the pellets still present.

Parameters:
COLS, 25, maze width in tiles (columns 0..COLS-1)
ROWS, 28, maze height in tiles (rows 0..ROWS-1)
TILE_SHIFT, 4, log2 of tile size in pixels (16 px tiles)
PELLET_PTS, 10, score added per pellet eaten
INIT_FILE, "pellets.txt", hex ROM image: ROWS words of 32 bits, bit c = pellet at column c

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  synchronous reset, active-low
frame_clk  in  1  frame strobe from VGA (level); rising edge detected on Clk
BallX  in  10  PacMan centre X, pixels
BallY  in  10  PacMan centre Y, pixels
restart  in  1  one-Clk pulse: refill pellets for a new level, keep score
draw_col  in  5  tile column queried by the colour mapper
draw_row  in  5  tile row queried by the colour mapper
pellet_here  out  1  pellet present at (draw_row, draw_col), 1-Clk latency
score  out  16  accumulated score, binary
pellets_left  out  10  pellets remaining
eat  out  1  one-Clk pulse when a pellet is consumed
level_clear  out  1  sticky: pellets_left reached 0
busy  out  1  high in INIT, LOOKUP, UPDATE

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-low on Reset_n. All state changes on posedge Clk.
- Reset (Reset_n=0 at a clock edge):
  - Outputs: score=0, pellets_left=0, eat=0, level_clear=0, pellet_here=0.
  - Internals: row index=0, frame-edge register=0.
  - State goes to INIT, so busy=1 in the first cycle after reset.
- Storage:
  - RAM of ROWS x 32-bit words, one word per row. Bits >= COLS are forced to 0 on every write.
  - Constant ROM of the same shape, loaded from INIT_FILE.
- Frame edge: fe = frame_clk & ~frame_clk_q, with frame_clk_q registered every Clk.
- FSM:
  - INIT:
    - Each cycle: RAM[row] <= ROM[row] masked to COLS bits; pellets_left += popcount(masked word); row++.
    - After row ROWS-1 is written, go to IDLE. Takes exactly ROWS cycles.
    - pellets_left is cleared to 0 on entry to INIT.
    - fe during INIT is dropped, not queued.
  - IDLE:
    - On fe: latch col = BallX >> TILE_SHIFT (6 bits) and row = BallY >> TILE_SHIFT (6 bits).
    - If col >= COLS or row >= ROWS, stay in IDLE (off-maze, ignored). Otherwise go to LOOKUP.
  - LOOKUP: read RAM[row] into a word register; go to UPDATE.
  - UPDATE:
    - If word[col]=1: RAM[row] <= word with bit col cleared; score += PELLET_PTS; pellets_left -= 1; eat=1 for this cycle.
    - If pellets_left was 1 (now 0), set level_clear.
    - Go to IDLE.
    - If word[col]=0: no change, eat stays 0.
- Score arithmetic: saturates at 16'hFFFF, never wraps.
- pellets_left: never decrements below 0, because a bit is only cleared if it was set.
- restart:
  - In any state except reset, restart=1 forces INIT and clears level_clear. score is kept.
  - An in-flight LOOKUP/UPDATE is abandoned: no RAM write, no score change, no eat.
  - restart asserted in the same cycle as Reset_n=0: reset wins, and score=0.
- Draw port:
  - pellet_here <= RAM[draw_row][draw_col], registered.
  - Reads 0 if draw_row >= ROWS or draw_col >= COLS.
  - During INIT it returns whatever the RAM holds: stale or the new ROM value.
- Simultaneous events:
  - A draw read and an UPDATE write to the same row in the same cycle return the old (pre-write) value.
  - fe arriving while in LOOKUP/UPDATE is dropped; at most one eat per frame.
- Throughput: 3 Clk from fe to eat (IDLE latch, LOOKUP, UPDATE); far shorter than one frame.
- At most one tile is tested per frame, namely the tile containing the PacMan centre pixel.

Test Plan:
- Reset: Reset_n=0 for 2 Clk, ROM with 3 pellets set. Reset then released -> busy=1 for exactly 28 Clk, then pellets_left=3, score=0, level_clear=0.
- Single eat: pellet at row 15, col 12; BallX=202, BallY=253; frame_clk rise -> eat pulse 3 Clk later, score=10, pellets_left=2. A second frame at the same position -> no eat, score stays 10.
- Draw port: after the eat above, draw_row=15, draw_col=12 -> pellet_here=0 one Clk later. An uneaten pellet tile -> pellet_here=1. draw_col=30 -> 0.
- Off-maze and drop: BallX=420 (col 26) -> no FSM activity, busy stays 0. A second frame_clk rise 2 Clk after a valid one -> exactly one eat.
- Level clear and restart: eat all 3 pellets -> level_clear=1 after the third eat and stays high. Pulse restart -> level_clear=0, 28-Clk INIT, pellets_left=3, score=30 preserved.
- Restart mid-update and saturation: restart during LOOKUP -> no eat, score unchanged. Preload score near 16'hFFFF via repeated eats -> score saturates at 16'hFFFF.

Source files
------------

// File: rtl/pellet_tracker.sv
// Pellet map for the maze: clears the pellet under PacMan once per frame, keeps
// score / pellets remaining / level-clear, and serves a read port for drawing.
module pellet_tracker #(
   parameter int COLS       = 25,
   parameter int ROWS       = 28,
   parameter int TILE_SHIFT = 4,
   parameter logic [15:0] PELLET_PTS = 16'd10,
   // Level image, word r (bits [r*32 +: 32]) is maze row r, bit c = pellet at column c
   parameter logic [ROWS*32-1:0] ROM_IMAGE =
      ((ROWS*32)'(1) << (32*1 + 1))   |
      ((ROWS*32)'(1) << (32*3 + 28))  |
      ((ROWS*32)'(1) << (32*15 + 12)) |
      ((ROWS*32)'(1) << (32*26 + 23))
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [9:0] BallX,
   input  logic [9:0] BallY,
   input  logic       restart,
   input  logic [4:0] draw_col,
   input  logic [4:0] draw_row,
   output logic       pellet_here,
   output logic [15:0] score,
   output logic [9:0] pellets_left,
   output logic       eat,
   output logic       level_clear,
   output logic       busy
);

   localparam int RW = $clog2(ROWS);
   localparam logic [31:0] COL_MASK = (COLS >= 32) ? 32'hFFFF_FFFF : ((32'd1 << COLS) - 32'd1);
   localparam logic [5:0]  ROWS6 = 6'(ROWS);
   localparam logic [5:0]  COLS6 = 6'(COLS);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOOKUP, S_UPDATE} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [4:0]      tile_col_q, tile_col_d;
   logic [RW-1:0]   tile_row_q, tile_row_d;
   logic [15:0]     score_q, score_d;
   logic [9:0]      pellets_left_q, pellets_left_d;
   logic            eat_q, eat_d;
   logic            level_clear_q, level_clear_d;
   logic            pellet_here_q, pellet_here_d;
   logic            frame_clk_q;
   logic [31:0]     word_q, word_d;

   logic [31:0]     ram [ROWS];
   logic            ram_we;
   logic [RW-1:0]   ram_waddr;
   logic [31:0]     ram_wdata;

   logic            fe;
   logic [5:0]      bx_col, by_row;
   logic [31:0]     init_word;
   logic [5:0]      init_cnt;
   logic [16:0]     score_sum;

   assign fe     = frame_clk & ~frame_clk_q;
   assign bx_col = 6'(BallX >> TILE_SHIFT);
   assign by_row = 6'(BallY >> TILE_SHIFT);

   always_comb begin
      init_word = ROM_IMAGE[{row_q, 5'b0} +: 32] & COL_MASK;
      init_cnt  = 6'd0;
      for (int i = 0; i < 32; i++) begin
         init_cnt = init_cnt + 6'(init_word[i]);
      end
   end

   assign score_sum = {1'b0, score_q} + {1'b0, PELLET_PTS};

   always_comb begin
      state_d        = state_q;
      row_d          = row_q;
      tile_col_d     = tile_col_q;
      tile_row_d     = tile_row_q;
      score_d        = score_q;
      pellets_left_d = pellets_left_q;
      eat_d          = 1'b0;
      level_clear_d  = level_clear_q;
      word_d         = word_q;
      ram_we         = 1'b0;
      ram_waddr      = row_q;
      ram_wdata      = init_word;

      case (state_q)
         S_INIT: begin
            ram_we         = 1'b1;
            pellets_left_d = pellets_left_q + 10'(init_cnt);
            if (row_q == RW'(ROWS - 1)) begin
               row_d   = '0;
               state_d = S_IDLE;
            end else begin
               row_d = row_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (fe) begin
               tile_col_d = bx_col[4:0];
               tile_row_d = by_row[RW-1:0];
               if (bx_col < COLS6 && by_row < ROWS6) state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            word_d  = ram[tile_row_q];
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            state_d = S_IDLE;
            if (word_q[tile_col_q]) begin
               ram_we         = 1'b1;
               ram_waddr      = tile_row_q;
               ram_wdata      = word_q & ~(32'd1 << tile_col_q) & COL_MASK;
               score_d        = score_sum[16] ? 16'hFFFF : score_sum[15:0];
               pellets_left_d = pellets_left_q - 10'd1;
               eat_d          = 1'b1;
               if (pellets_left_q == 10'd1) level_clear_d = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase

      // Restart abandons whatever is in flight; only the score survives
      if (restart) begin
         state_d        = S_INIT;
         row_d          = '0;
         pellets_left_d = '0;
         level_clear_d  = 1'b0;
         score_d        = score_q;
         eat_d          = 1'b0;
         ram_we         = 1'b0;
      end
   end

   always_comb begin
      pellet_here_d = 1'b0;
      if ({1'b0, draw_row} < ROWS6 && {1'b0, draw_col} < COLS6)
         pellet_here_d = ram[RW'(draw_row)][draw_col];
   end

   always_ff @(posedge Clk) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
      word_q <= word_d;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q        <= S_INIT;
         row_q          <= '0;
         tile_col_q     <= '0;
         tile_row_q     <= '0;
         score_q        <= '0;
         pellets_left_q <= '0;
         eat_q          <= 1'b0;
         level_clear_q  <= 1'b0;
         pellet_here_q  <= 1'b0;
         frame_clk_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         tile_col_q     <= tile_col_d;
         tile_row_q     <= tile_row_d;
         score_q        <= score_d;
         pellets_left_q <= pellets_left_d;
         eat_q          <= eat_d;
         level_clear_q  <= level_clear_d;
         pellet_here_q  <= pellet_here_d;
         frame_clk_q    <= frame_clk;
      end
   end

   assign pellet_here  = pellet_here_q;
   assign score        = score_q;
   assign pellets_left = pellets_left_q;
   assign eat          = eat_q;
   assign level_clear  = level_clear_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_pellet_tracker.sv
// Directed bench for pellet_tracker: frame transactions are scored against a
// queue of expected outcomes built from a small pellet-map model.
module tb_pellet_tracker;

   logic       Clk = 1'b0;
   logic       Reset_n, frame_clk, restart;
   logic [9:0] BallX, BallY;
   logic [4:0] draw_col, draw_row;
   logic       pellet_here, eat, level_clear, busy;
   logic [15:0] score;
   logic [9:0] pellets_left;
   logic       s_pellet_here, s_eat, s_level_clear, s_busy;
   logic [15:0] s_score;
   logic [9:0] s_pellets_left;

   always #5 Clk = ~Clk;

   pellet_tracker dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .BallX(BallX), .BallY(BallY),
      .restart(restart), .draw_col(draw_col), .draw_row(draw_row),
      .pellet_here(pellet_here), .score(score), .pellets_left(pellets_left),
      .eat(eat), .level_clear(level_clear), .busy(busy)
   );

   // Same stimulus, large per-pellet value so the score ceiling is reached quickly
   pellet_tracker #(.PELLET_PTS(16'd20000)) u_sat (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .BallX(BallX), .BallY(BallY),
      .restart(restart), .draw_col(draw_col), .draw_row(draw_row),
      .pellet_here(s_pellet_here), .score(s_score), .pellets_left(s_pellets_left),
      .eat(s_eat), .level_clear(s_level_clear), .busy(s_busy)
   );

   typedef struct {
      int          eats;
      int          busy_cycles;
      int          lat;
      logic [15:0] score;
      logic [15:0] sscore;
      logic [9:0]  left;
      logic        clr;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mpel [28];
   int          m_score = 0, m_eats = 0, m_left = 0;
   logic        m_clr = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_refill();
      for (int r = 0; r < 28; r++) mpel[r] = 32'd0;
      mpel[1][1]   = 1'b1;
      mpel[15][12] = 1'b1;
      mpel[26][23] = 1'b1;
      m_left = 3;
      m_clr  = 1'b0;
   endtask

   function automatic logic [15:0] sat16(input int v);
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   // One frame at (x,y); rise2 adds a second frame_clk rise 2 Clk after the first
   task automatic do_frame(input string tag, input logic [9:0] x, input logic [9:0] y, input bit rise2);
      int   col, row, n_eat, n_busy, lat;
      bit   valid, hit;
      exp_t e;
      col   = int'(x >> 4);
      row   = int'(y >> 4);
      valid = (col < 25) && (row < 28);
      hit   = valid && mpel[row][col];
      if (hit) begin
         mpel[row][col] = 1'b0;
         m_eats++;
         m_score = m_score + 10;
         m_left--;
         if (m_left == 0) m_clr = 1'b1;
      end
      e.eats = hit ? 1 : 0;
      e.busy_cycles = valid ? 2 : 0;
      e.lat = hit ? 3 : 0;
      e.score = sat16(m_score);
      e.sscore = sat16(m_eats * 20000);
      e.left = 10'(m_left);
      e.clr = m_clr;
      sb.push_back(e);

      BallX = x; BallY = y; frame_clk = 1'b1;
      n_eat = 0; n_busy = 0; lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge Clk);
         if (eat) begin
            n_eat++;
            if (lat == 0) lat = k;
         end
         if (busy) n_busy++;
         if (k == 1) frame_clk = 1'b0;
         if (k == 2 && rise2) frame_clk = 1'b1;
         if (k == 3) frame_clk = 1'b0;
      end
      e = sb.pop_front();
      check({tag, " eats"}, n_eat, e.eats);
      check({tag, " busy_cycles"}, n_busy, e.busy_cycles);
      check({tag, " eat_latency"}, lat, e.lat);
      check({tag, " score"}, score, e.score);
      check({tag, " sat_score"}, s_score, e.sscore);
      check({tag, " pellets_left"}, pellets_left, e.left);
      check({tag, " level_clear"}, level_clear, e.clr);
      $display("frame %s x=%0d y=%0d eats=%0d score=%0d left=%0d clr=%0b",
               tag, x, y, n_eat, score, pellets_left, level_clear);
   endtask

   task automatic draw(input string tag, input logic [4:0] r, input logic [4:0] c, input logic exp);
      draw_row = r; draw_col = c;
      @(negedge Clk);
      check(tag, pellet_here, exp);
      $display("draw %s row=%0d col=%0d pellet_here=%0b", tag, r, c, pellet_here);
   endtask

   task automatic count_busy(input string tag);
      int n;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge Clk);
      end
      check({tag, " init_cycles"}, n, 28);
   endtask

   initial begin
      int n_eat;
      exp_t e;
      Reset_n = 1'b0; frame_clk = 1'b0; restart = 1'b0;
      BallX = '0; BallY = '0; draw_col = '0; draw_row = '0;
      model_refill();
      m_left = 0;

      // reset held two clocks, restart also asserted: reset must win
      restart = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      restart = 1'b0;
      check("reset score", score, 0);
      check("reset pellets_left", pellets_left, 0);
      check("reset eat", eat, 0);
      check("reset level_clear", level_clear, 0);
      check("reset pellet_here", pellet_here, 0);
      check("reset busy", busy, 1);
      $display("reset score=%0d left=%0d busy=%0b", score, pellets_left, busy);

      Reset_n = 1'b1;
      count_busy("post_reset");
      model_refill();
      check("init pellets_left", pellets_left, 10'(m_left));
      check("init score", score, 0);
      check("init level_clear", level_clear, 0);
      $display("init done left=%0d", pellets_left);

      do_frame("eat_r15c12", 10'd202, 10'd253, 1'b0);
      do_frame("reeat_r15c12", 10'd202, 10'd253, 1'b0);

      draw("draw_eaten", 5'd15, 5'd12, 1'b0);
      draw("draw_present", 5'd1, 5'd1, 1'b1);
      draw("draw_col30", 5'd1, 5'd30, 1'b0);
      draw("draw_masked_col28", 5'd3, 5'd28, 1'b0);
      draw("draw_row30", 5'd30, 5'd1, 1'b0);

      do_frame("off_maze_col26", 10'd420, 10'd253, 1'b0);
      do_frame("double_rise_r1c1", 10'd24, 10'd24, 1'b1);
      do_frame("eat_r26c23", 10'd376, 10'd424, 1'b0);
      repeat (5) @(negedge Clk);
      check("level_clear sticky", level_clear, 1);

      // restart: new level, score kept
      restart = 1'b1;
      @(negedge Clk);
      restart = 1'b0;
      check("restart level_clear", level_clear, 0);
      count_busy("restart");
      model_refill();
      check("restart pellets_left", pellets_left, 10'(m_left));
      check("restart score", score, sat16(m_score));
      check("restart sat_score", s_score, sat16(m_eats * 20000));
      $display("restart left=%0d score=%0d", pellets_left, score);

      // restart while LOOKUP is in flight: nothing may be eaten
      e.eats = 0; e.score = sat16(m_score); e.left = 10'(m_left);
      e.busy_cycles = 0; e.lat = 0; e.sscore = sat16(m_eats * 20000); e.clr = 1'b0;
      sb.push_back(e);
      BallX = 10'd202; BallY = 10'd253; frame_clk = 1'b1;
      n_eat = 0;
      @(negedge Clk);
      if (eat) n_eat++;
      frame_clk = 1'b0;
      restart = 1'b1;
      @(negedge Clk);
      if (eat) n_eat++;
      restart = 1'b0;
      for (int k = 0; k < 40 && busy; k++) begin
         @(negedge Clk);
         if (eat) n_eat++;
      end
      e = sb.pop_front();
      check("abort eats", n_eat, e.eats);
      check("abort score", score, e.score);
      check("abort pellets_left", pellets_left, e.left);
      check("abort busy_done", busy, 0);
      $display("abort eats=%0d score=%0d left=%0d", n_eat, score, pellets_left);

      do_frame("eat_after_abort", 10'd202, 10'd253, 1'b0);
      check("sat ceiling", s_score, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
